// File: rtl/tanh_pkg.sv
// Shared constants for the tanh approximator and its request controller.
// Fixed-point scale, range breakpoints and the controller FSM encoding.
package tanh_pkg;

    localparam int DEF_DATA_W = 32;

    // Fixed-point 1.0 and the range breakpoints (0.2 and 0.86 of ONE)
    localparam logic [31:0] ONE    = 32'h00005B47;
    localparam logic [31:0] BP_LIN = 32'h00001241;
    localparam logic [31:0] BP_SAT = 32'h00004E80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/tanh_req_ctrl.sv
// Request controller driving the tanh approximator's en/data_in/done/data_out port.
// Latency: result valid 4 (2-step) or 5 (3-step) cycles after accept; timeout after TIMEOUT_CYCLES.
// Backpressure: in_ready drops while a result is pending; out_data/out_err hold until out_ready.
module tanh_req_ctrl #(
    parameter int DATA_W         = tanh_pkg::DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int TO_W           = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic              busy,
    output logic              act_en,
    output logic [DATA_W-1:0] act_data,
    input  logic              act_done,
    input  logic [DATA_W-1:0] act_result
);
    import tanh_pkg::*;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              act_en_q, act_en_d;
    logic [DATA_W-1:0] act_data_q, act_data_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic              err_sticky_q, err_sticky_d;

    // No path from out_ready: a new operand waits until the pending result is gone.
    assign in_ready   = (state_q == ST_IDLE) && !out_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign act_en     = act_en_q;
    assign act_data   = act_data_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign err_sticky = err_sticky_q;

    always_comb begin
        state_d      = state_q;
        act_en_d     = act_en_q;
        act_data_d   = act_data_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        err_sticky_d = err_sticky_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    act_data_d = in_data;
                    act_en_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (act_done) begin
                    out_data_d  = act_result;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    act_en_d    = 1'b0;
                    state_d     = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    // Written after the clear above so a timeout beats err_clr.
                    out_data_d   = '0;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    err_sticky_d = 1'b1;
                    act_en_d     = 1'b0;
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                act_en_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            act_en_q     <= 1'b0;
            act_data_q   <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_en_q     <= act_en_d;
            act_data_q   <= act_data_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

endmodule

// File: tb/tb_tanh_req_ctrl.sv
// Bench for tanh_req_ctrl with a behavioural approximator stand-in and a result scoreboard.
// Table vectors, hand-written backpressure/timeout/reset sequences, then randomized traffic.
module tb_tanh_req_ctrl;
    import tanh_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        err_sticky;
    logic        err_clr;
    logic        busy;
    logic        act_en;
    logic [31:0] act_data;
    logic        act_done;
    logic [31:0] act_result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tanh_req_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .busy       (busy),
        .act_en     (act_en),
        .act_data   (act_data),
        .act_done   (act_done),
        .act_result (act_result)
    );

    // Reference transfer function; the mid range is an arbitrary stand-in line.
    function automatic logic [31:0] model_res(input logic [31:0] x);
        logic [31:0] a, r;
        a = x[31] ? (32'd0 - x) : x;
        if (a < BP_LIN)       r = a;
        else if (a >= BP_SAT) r = ONE;
        else                  r = (a >> 1) + 32'h000010A2;
        return x[31] ? (32'd0 - r) : r;
    endfunction

    function automatic int model_steps(input logic [31:0] x);
        logic [31:0] a;
        a = x[31] ? (32'd0 - x) : x;
        return ((a < BP_LIN) || (a >= BP_SAT)) ? 2 : 3;
    endfunction

    // Approximator stand-in: done/data_out registered after N en-high edges; stub_dead ties done low.
    logic     stub_dead;
    int       st_step;
    always @(posedge clk) begin
        if (!act_en || stub_dead) begin
            st_step  <= 0;
            act_done <= 1'b0;
        end else begin
            st_step <= st_step + 1;
            if (st_step + 1 >= model_steps(act_data)) begin
                act_done   <= 1'b1;
                act_result <= model_res(act_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] d, input logic dead, input int exp_lat,
                          input logic [31:0] exp_d, input logic exp_err, input logic exp_sticky);
        int g, lat, en_cnt;
        stub_dead = dead;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin
            step();
            g++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("act_en_after_accept", 32'(act_en), 32'd1);
        chk("act_data_captured", act_data, d);
        chk("busy_in_run", 32'(busy), 32'd1);
        lat = 1;
        en_cnt = 0;
        while (!out_valid && lat < 30) begin
            if (act_en) en_cnt++;
            step();
            lat++;
        end
        chk("out_valid_latency", 32'(lat), 32'(exp_lat));
        chk("act_en_high_cycles", 32'(en_cnt), 32'(exp_lat - 1));
        chk("out_data", out_data, exp_d);
        chk("out_err", 32'(out_err), 32'(exp_err));
        chk("err_sticky_at_result", 32'(err_sticky), 32'(exp_sticky));
        chk("act_en_low_at_result", 32'(act_en), 32'd0);
        step();
        chk("out_valid_consumed", 32'(out_valid), 32'd0);
        chk("act_en_low_gap", 32'(act_en), 32'd0);
        chk("busy_back_idle", 32'(busy), 32'd0);
        stub_dead = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 2))
            0:       v = 32'($urandom_range(0, 32'h1240));
            1:       v = 32'($urandom_range(32'h1241, 32'h4E7F));
            default: v = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
        return v;
    endfunction

    typedef struct {
        logic [31:0] din;
        logic        dead;
        int          lat;
        logic [31:0] dout;
        logic        err;
        logic        sticky;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] e, od;
        logic        oe, acc, cons, seen;
        int          g, n_done;

        tbl[0] = '{32'h00001000, 1'b0, 4, 32'h00001000, 1'b0, 1'b0};
        tbl[1] = '{32'h00020000, 1'b0, 4, 32'h00005B47, 1'b0, 1'b0};
        tbl[2] = '{32'h80000001, 1'b0, 4, 32'hFFFFA4B9, 1'b0, 1'b0};
        tbl[3] = '{32'h00003000, 1'b0, 5, 32'h000028A2, 1'b0, 1'b0};
        tbl[4] = '{32'h00001234, 1'b1, 9, 32'h00000000, 1'b1, 1'b1};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        stub_dead = 1'b0;
        step();
        step();
        chk("rst_act_en", 32'(act_en), 32'd0);
        chk("rst_act_data", act_data, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].din, tbl[i].dead, tbl[i].lat, tbl[i].dout, tbl[i].err, tbl[i].sticky);
        end

        // Sticky error clears on err_clr; next good op reports no error.
        chk("sticky_held", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("sticky_cleared", 32'(err_sticky), 32'd0);
        run_op(32'h00001000, 1'b0, 4, 32'h00001000, 1'b0, 1'b0);

        // Timeout with err_clr held high: the set must win on the timeout edge.
        err_clr = 1'b1;
        run_op(32'h00000777, 1'b1, 9, 32'h00000000, 1'b1, 1'b1);
        chk("sticky_clr_after_set", 32'(err_sticky), 32'd0);
        err_clr = 1'b0;

        // Backpressure: second operand held while the first result is stalled.
        out_ready = 1'b0;
        in_data   = 32'h00001000;
        in_valid  = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin step(); g++; end
        step();
        in_data = 32'h00003000;
        g = 0;
        while (!out_valid && g < 20) begin step(); g++; end
        for (int k = 0; k < 4; k++) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_out_data_stable", out_data, 32'h00001000);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_consumed", 32'(out_valid), 32'd0);
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_second_accept", 32'(act_en), 32'd1);
        chk("bp_second_data", act_data, 32'h00003000);
        g = 0;
        while (!out_valid && g < 20) begin step(); g++; end
        chk("bp_second_result", out_data, 32'h000028A2);
        step();
        step();

        // Reset two cycles into RUN: outputs drop at once and nothing emerges later.
        err_clr   = 1'b0;
        stub_dead = 1'b1;
        in_data   = 32'h00004000;
        in_valid  = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin step(); g++; end
        step();
        in_valid = 1'b0;
        step();
        step();
        rstn = 1'b0;
        #1;
        chk("arst_act_en", 32'(act_en), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        step();
        step();
        rstn = 1'b1;
        stub_dead = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || act_en) seen = 1'b1;
            step();
        end
        chk("arst_no_result", 32'(seen), 32'd0);

        // Randomized traffic against the scoreboard.
        n_done = 0;
        for (int cyc = 0; cyc < 4000 && n_done < 150; cyc++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = rand_operand();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            od   = out_data;
            oe   = out_err;
            if (acc) exp_q.push_back(model_res(in_data));
            if (cons) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_out_data", od, e);
                    chk("rand_out_err", 32'(oe), 32'd0);
                end
                n_done++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("rand_ops_completed", 32'(n_done >= 150), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
